sine_sweep_ctrl: RTL and testbench
==================================

// Module: sine_sweep_ctrl
// PURPOSE
//  Sequencer for the phase-accumulator sine generator: drives its 12-bit frequency word (delta)
//  and its active-low reset. Runs a stepped frequency sweep f_start -> f_stop, holding each
//  word for a programmable dwell. Supports single-shot and continuous (repeat) modes.
//  Sits between the register/config logic and the sine generator.
// PARAMETERS
//  DW      12  frequency-word width (must match generator delta width)
//  DWELL_W 16  dwell counter width
// PORTS
//  clk      in  1       system clock, all logic on rising edge
//  rst      in  1       reset, asynchronous, active-low
//  start    in  1       1-cycle pulse: latch config and begin sweep (honoured in IDLE only)
//  abort    in  1       stop sweep immediately (any state)
//  cont     in  1       0 = single sweep, 1 = repeat from f_start after f_stop dwell
//  f_start  in  DW      first frequency word
//  f_stop   in  DW      last frequency word (direction = up if f_stop >= f_start, else down)
//  f_step   in  DW      step magnitude per dwell period
//  dwell    in  DWELL_W cycles per frequency word (0 treated as 1)
//  delta    out DW      frequency word to generator
//  gen_rstn out 1       generator reset, active-low; 0 whenever not sweeping
//  busy     out 1       1 while in RUN
//  step_stb out 1       1-cycle pulse on each delta change inside a sweep (incl. wrap reload)
//  wrap     out 1       1-cycle pulse when continuous mode reloads f_start
//  done     out 1       1-cycle pulse on normal single-sweep completion
// BEHAVIOUR
//  Reset (rst=0): state IDLE; delta=0, gen_rstn=0, busy=0, step_stb=0, wrap=0, done=0;
//   config registers and dwell counter cleared.
//  All outputs registered. States: IDLE, RUN, FIN.
//  IDLE: start=1 & abort=0 -> latch f_start/f_stop/f_step/dwell/cont/direction; next cycle
//   delta=f_start, gen_rstn=1, busy=1, dwell counter loaded to max(dwell,1)-1 -> RUN.
//   start & abort same cycle -> stay IDLE. Inputs other than start/abort ignored outside IDLE.
//  RUN: counter decrements each cycle; delta held. At counter==0:
//   - delta != f_stop and f_step != 0: delta <= next, counter reloads, step_stb=1.
//     next = delta +/- f_step computed in DW+1 bits; if result passes f_stop or over/underflows
//     DW bits, next = f_stop (saturate, never wraps).
//   - delta == f_stop or f_step == 0 (sweep end): cont=1 -> delta <= f_start, reload,
//     step_stb=1, wrap=1, gen_rstn stays 1 (phase continuous); cont=0 -> FIN.
//  Each frequency word is therefore present for exactly max(dwell,1) cycles.
//  FIN (1 cycle): done=1, busy=0, gen_rstn=0, delta=0 -> IDLE. start in FIN ignored.
//  abort=1 in RUN or FIN: next cycle IDLE, delta=0, gen_rstn=0, busy=0, no done/wrap/step_stb.
//  f_start == f_stop: one dwell at f_start, then end-of-sweep handling as above.
//  start in RUN ignored (no restart); latched config unaffected by input changes mid-sweep.
//  Async reset mid-sweep: immediate return to reset values, no done pulse.
// STRUCTURE
//  Package sine_sweep_pkg: state enum (IDLE/RUN/FIN), DW/DWELL_W defaults,
//   direction encoding (DIR_UP/DIR_DN).
//  Sub-module sweep_next_word: combinational saturating next-delta (cur, step, stop, dir ->
//   next, at_stop). Top holds FSM, config latch, dwell counter, output registers.
// TESTING
//  T1 up sweep: f_start=100,f_stop=400,f_step=100,dwell=4,cont=0 -> delta 100,200,300,400
//   each 4 cycles, 3 step_stb, done 1 cycle after last 400 cycle, gen_rstn low with done.
//  T2 down+saturate: f_start=1000,f_stop=50,f_step=300,dwell=2 -> 1000,700,400,100,50; done.
//  T3 overflow clamp: f_start=4000,f_stop=4095,f_step=200,dwell=1 -> 4000,4095; no wrap to low.
//  T4 continuous: f_start=10,f_stop=30,f_step=10,dwell=3,cont=1 -> 10,20,30,10,... wrap pulse
//   on each reload, gen_rstn never drops, no done; abort -> next cycle delta=0, busy=0.
//  T5 edge: dwell=0 -> 1 cycle per word; f_step=0 -> single dwell at f_start then done;
//   start+abort same cycle in IDLE -> no busy.
//  T6 reset/start mid-sweep: start pulse during RUN ignored; rst low mid-RUN -> all outputs
//   reset values immediately, no done; new start after release sweeps normally.

Source files
------------

// File: rtl/sine_sweep_pkg.sv
// Shared types and defaults for the sine sweep sequencer.
package sine_sweep_pkg;

    localparam int DW_DEF      = 12;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

endpackage

// File: rtl/sweep_next_word.sv
// Combinational saturating next frequency word. The step result never
// goes past the stop word and never wraps around the DW-bit range.
module sweep_next_word
    import sine_sweep_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] step,
    input  logic [DW-1:0] stop,
    input  dir_t          dir,
    output logic [DW-1:0] next,
    output logic          at_stop
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    // One extra bit catches carry-out (up) and borrow (down)
    always_comb begin
        sum     = {1'b0, cur} + {1'b0, step};
        diff    = {1'b0, cur} - {1'b0, step};
        at_stop = (cur == stop);
        next    = stop;
        if (dir == DIR_UP) begin
            if (!sum[DW] && (sum[DW-1:0] <= stop))
                next = sum[DW-1:0];
        end else begin
            if (!diff[DW] && (diff[DW-1:0] >= stop))
                next = diff[DW-1:0];
        end
    end

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Stepped frequency sweep sequencer driving the phase-accumulator sine
// generator. Every output is registered; each word is held for
// max(dwell,1) cycles.
module sine_sweep_ctrl
    import sine_sweep_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               cont,
    input  logic [DW-1:0]      f_start,
    input  logic [DW-1:0]      f_stop,
    input  logic [DW-1:0]      f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [DW-1:0]      delta,
    output logic               gen_rstn,
    output logic               busy,
    output logic               step_stb,
    output logic               wrap,
    output logic               done
);

    state_t               state, state_n;
    logic [DWELL_W-1:0]   cnt, cnt_n;
    logic [DW-1:0]        fstart_r, fstart_n;
    logic [DW-1:0]        fstop_r, fstop_n;
    logic [DW-1:0]        fstep_r, fstep_n;
    logic [DWELL_W-1:0]   dwell_r, dwell_n;
    logic                 cont_r, cont_n;
    dir_t                 dir_r, dir_n;
    logic [DW-1:0]        delta_n;
    logic                 gen_rstn_n, busy_n, step_stb_n, wrap_n, done_n;
    logic [DW-1:0]        nxt;
    logic                 at_stop;
    logic [DWELL_W-1:0]   dwell_m1;

    assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    sweep_next_word #(.DW(DW)) u_next (
        .cur     (delta),
        .step    (fstep_r),
        .stop    (fstop_r),
        .dir     (dir_r),
        .next    (nxt),
        .at_stop (at_stop)
    );

    // State, config latch, dwell counter and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            fstart_r <= '0;
            fstop_r  <= '0;
            fstep_r  <= '0;
            dwell_r  <= '0;
            cont_r   <= 1'b0;
            dir_r    <= DIR_UP;
            delta    <= '0;
            gen_rstn <= 1'b0;
            busy     <= 1'b0;
            step_stb <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            fstart_r <= fstart_n;
            fstop_r  <= fstop_n;
            fstep_r  <= fstep_n;
            dwell_r  <= dwell_n;
            cont_r   <= cont_n;
            dir_r    <= dir_n;
            delta    <= delta_n;
            gen_rstn <= gen_rstn_n;
            busy     <= busy_n;
            step_stb <= step_stb_n;
            wrap     <= wrap_n;
            done     <= done_n;
        end
    end

    // Next-state and next-output logic; pulses default low
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        fstart_n   = fstart_r;
        fstop_n    = fstop_r;
        fstep_n    = fstep_r;
        dwell_n    = dwell_r;
        cont_n     = cont_r;
        dir_n      = dir_r;
        delta_n    = '0;
        gen_rstn_n = 1'b0;
        busy_n     = 1'b0;
        step_stb_n = 1'b0;
        wrap_n     = 1'b0;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    fstart_n   = f_start;
                    fstop_n    = f_stop;
                    fstep_n    = f_step;
                    dwell_n    = dwell_m1;
                    cont_n     = cont;
                    dir_n      = (f_stop >= f_start) ? DIR_UP : DIR_DN;
                    cnt_n      = dwell_m1;
                    delta_n    = f_start;
                    gen_rstn_n = 1'b1;
                    busy_n     = 1'b1;
                    state_n    = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    delta_n    = delta;
                    gen_rstn_n = 1'b1;
                    busy_n     = 1'b1;
                    if (cnt != '0) begin
                        cnt_n = cnt - DWELL_W'(1);
                    end else if (!at_stop && (fstep_r != '0)) begin
                        delta_n    = nxt;
                        cnt_n      = dwell_r;
                        step_stb_n = 1'b1;
                    end else if (cont_r) begin
                        // Reload keeps the generator running: phase stays continuous
                        delta_n    = fstart_r;
                        cnt_n      = dwell_r;
                        step_stb_n = 1'b1;
                        wrap_n     = 1'b1;
                    end else begin
                        delta_n    = '0;
                        gen_rstn_n = 1'b0;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        state_n    = FIN;
                    end
                end
            end
            FIN: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Directed bench for the sine sweep sequencer.
module tb_sine_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cont = 1'b0;
    logic [11:0] f_start = '0;
    logic [11:0] f_stop = '0;
    logic [11:0] f_step = '0;
    logic [15:0] dwell = '0;
    logic [11:0] delta;
    logic        gen_rstn, busy, step_stb, wrap, done;

    int checks = 0;
    int failures = 0;

    sine_sweep_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cont     (cont),
        .f_start  (f_start),
        .f_stop   (f_stop),
        .f_step   (f_step),
        .dwell    (dwell),
        .delta    (delta),
        .gen_rstn (gen_rstn),
        .busy     (busy),
        .step_stb (step_stb),
        .wrap     (wrap),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags = {gen_rstn, busy, step_stb, wrap, done}
    task automatic chk_st(input string tag, input int exp_delta, input logic [4:0] exp_flags);
        chk({tag, "_delta"}, 32'(delta), 32'(exp_delta));
        chk({tag, "_flags"}, 32'({gen_rstn, busy, step_stb, wrap, done}), 32'(exp_flags));
    endtask

    task automatic run_word(input string tag, input int val, input int n, input logic stb, input logic wr);
        for (int i = 0; i < n; i++) begin
            chk_st(tag, val, {1'b1, 1'b1, (i == 0) ? stb : 1'b0, (i == 0) ? wr : 1'b0, 1'b0});
            tick();
        end
    endtask

    task automatic do_start(input int fs, input int fe, input int st, input int dw, input logic c);
        f_start = 12'(fs);
        f_stop  = 12'(fe);
        f_step  = 12'(st);
        dwell   = 16'(dw);
        cont    = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        chk_st("reset", 0, 5'b00000);
        tick();
        rst = 1'b1;
        tick();
        chk_st("idle0", 0, 5'b00000);

        // T1 up sweep; inputs scrambled after start must not matter
        do_start(100, 400, 100, 4, 1'b0);
        f_stop = 12'd0; f_step = 12'd1; dwell = 16'd1; cont = 1'b1;
        run_word("t1_100", 100, 4, 1'b0, 1'b0);
        run_word("t1_200", 200, 4, 1'b1, 1'b0);
        run_word("t1_300", 300, 4, 1'b1, 1'b0);
        run_word("t1_400", 400, 4, 1'b1, 1'b0);
        chk_st("t1_fin", 0, 5'b00001);
        tick();
        chk_st("t1_idle", 0, 5'b00000);

        // T2 down sweep with underflow clamp to f_stop
        do_start(1000, 50, 300, 2, 1'b0);
        run_word("t2_1000", 1000, 2, 1'b0, 1'b0);
        run_word("t2_700", 700, 2, 1'b1, 1'b0);
        run_word("t2_400", 400, 2, 1'b1, 1'b0);
        run_word("t2_100", 100, 2, 1'b1, 1'b0);
        run_word("t2_50", 50, 2, 1'b1, 1'b0);
        chk_st("t2_fin", 0, 5'b00001);
        tick();
        chk_st("t2_idle", 0, 5'b00000);

        // T3 overflow clamp at top of range
        do_start(4000, 4095, 200, 1, 1'b0);
        run_word("t3_4000", 4000, 1, 1'b0, 1'b0);
        run_word("t3_4095", 4095, 1, 1'b1, 1'b0);
        chk_st("t3_fin", 0, 5'b00001);
        tick();
        chk_st("t3_idle", 0, 5'b00000);

        // T4 continuous mode with wrap, then abort
        do_start(10, 30, 10, 3, 1'b1);
        run_word("t4_10a", 10, 3, 1'b0, 1'b0);
        run_word("t4_20a", 20, 3, 1'b1, 1'b0);
        run_word("t4_30a", 30, 3, 1'b1, 1'b0);
        run_word("t4_10b", 10, 3, 1'b1, 1'b1);
        run_word("t4_20b", 20, 3, 1'b1, 1'b0);
        run_word("t4_30b", 30, 3, 1'b1, 1'b0);
        run_word("t4_10c", 10, 1, 1'b1, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_st("t4_abort", 0, 5'b00000);
        tick();
        chk_st("t4_idle", 0, 5'b00000);

        // T5a dwell=0 behaves as one cycle per word
        do_start(5, 7, 1, 0, 1'b0);
        run_word("t5_5", 5, 1, 1'b0, 1'b0);
        run_word("t5_6", 6, 1, 1'b1, 1'b0);
        run_word("t5_7", 7, 1, 1'b1, 1'b0);
        chk_st("t5a_fin", 0, 5'b00001);
        tick();

        // T5b zero step: one dwell at f_start then done
        do_start(300, 900, 0, 3, 1'b0);
        run_word("t5b_300", 300, 3, 1'b0, 1'b0);
        chk_st("t5b_fin", 0, 5'b00001);
        tick();
        chk_st("t5b_idle", 0, 5'b00000);

        // T5c start and abort together in IDLE
        f_start = 12'd123;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_st("t5c_noStart", 0, 5'b00000);
        tick();
        chk_st("t5c_idle", 0, 5'b00000);

        // T6 start mid-sweep ignored, async reset mid-RUN, then fresh sweep
        do_start(100, 400, 100, 4, 1'b0);
        run_word("t6_100", 100, 4, 1'b0, 1'b0);
        start = 1'b1; f_start = 12'd7; f_step = 12'd1;
        run_word("t6_200", 200, 4, 1'b1, 1'b0);
        start = 1'b0;
        run_word("t6_300", 300, 2, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        chk_st("t6_rst", 0, 5'b00000);
        tick();
        chk_st("t6_rst_hold", 0, 5'b00000);
        rst = 1'b1;
        tick();
        chk_st("t6_rel", 0, 5'b00000);
        // f_start == f_stop: single dwell, then completion
        do_start(77, 77, 5, 2, 1'b0);
        run_word("t6_77", 77, 2, 1'b0, 1'b0);
        chk_st("t6_fin", 0, 5'b00001);
        tick();
        chk_st("t6_idle", 0, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
